instr_encoder_loader: RTL and testbench

Sequential RV32I instruction encoder and instruction-memory loader. It accepts one decoded instruction description per valid/ready handshake and packs it into a 32-bit machine word. It then writes that word into instruction memory at an auto-incrementing word address. It sits between the boot/debug front end and the instruction memory, and covers the same opcode set the main control decoder recognises: lw, sw, R-type, beq, I-type ALU and jal.

---
 rtl/instr_encoder_loader_if.sv | 31 +++
 rtl/instr_encoder_loader.sv | 114 +++++++++++
 tb/tb_instr_encoder_loader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_loader_if.sv
// Descriptor handshake and instruction-memory write bus for instr_encoder_loader.
// master drives descriptors and observes the memory side; slave is the encoder/loader.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        in_class;
  logic [4:0]        in_rd;
  logic [4:0]        in_rs1;
  logic [4:0]        in_rs2;
  logic [2:0]        in_funct3;
  logic              in_funct7b5;
  logic [31:0]       in_imm;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              err;

  modport master (
    output in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );

  modport slave (
    input  in_valid, in_class, in_rd, in_rs1, in_rs2, in_funct3, in_funct7b5, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, count, full, err
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// RV32I instruction encoder that writes each packed word to instruction memory at an
// auto-incrementing address. Define ENC_RANGE_CHECK_EN to reject out-of-range immediates.
module instr_encoder_loader #(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  instr_encoder_loader_if.slave bus,
  output logic [1:0]            dbg_state
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_q, state_n;
  logic            mem_we_q;
  logic [31:0]     mem_addr_q;
  logic [31:0]     mem_wdata_q;
  logic [ADDR_W:0] count_q;
  logic            err_q;
  logic [31:0]     enc_word;
  logic            enc_legal;
  logic            accept;
  logic [31:0]     imm;
  logic [6:0]      f7;

  // Handshake: a descriptor transfers on a rising edge where in_valid && in_ready
  // and clr is low; in_ready depends only on state, never on in_valid.
  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.full      = (state_q == S_FULL);
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.count     = count_q;
  assign bus.err       = err_q;
  assign dbg_state     = state_q;

  assign accept = (state_q == S_IDLE) && bus.in_valid && !clr;
  assign imm    = bus.in_imm;
  assign f7     = {1'b0, bus.in_funct7b5, 5'b00000};

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (bus.in_class)
      3'd0: enc_word = {imm[11:0], bus.in_rs1, 3'b010, bus.in_rd, 7'b0000011};
      3'd1: enc_word = {imm[11:5], bus.in_rs2, bus.in_rs1, 3'b010, imm[4:0], 7'b0100011};
      3'd2: enc_word = {f7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0110011};
      3'd3: enc_word = {imm[12], imm[10:5], bus.in_rs2, bus.in_rs1, 3'b000,
                        imm[4:1], imm[11], 7'b1100011};
      3'd4: enc_word = {imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, 7'b0010011};
      3'd5: enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.in_rd, 7'b1101111};
      default: enc_legal = 1'b0;
    endcase
`ifdef ENC_RANGE_CHECK_EN
    case (bus.in_class)
      3'd0, 3'd1, 3'd4:
        if ($signed(imm) < -32'sd2048 || $signed(imm) > 32'sd2047) enc_legal = 1'b0;
      3'd3:
        if ($signed(imm) < -32'sd4096 || $signed(imm) > 32'sd4094 || imm[0]) enc_legal = 1'b0;
      3'd5:
        if ($signed(imm) < -32'sd1048576 || $signed(imm) > 32'sd1048574 || imm[0])
          enc_legal = 1'b0;
      default: ;
    endcase
`endif
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      S_IDLE:  if (accept && enc_legal) state_n = S_WRITE;
      S_WRITE: begin
        if (clr)                       state_n = S_IDLE;
        else if (count_q + ONE == CAP) state_n = S_FULL;
        else                           state_n = S_IDLE;
      end
      S_FULL:  if (clr) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= 32'h0;
      count_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q  <= state_n;
      mem_we_q <= accept && enc_legal;
      if (accept && enc_legal) mem_wdata_q <= enc_word;
      // A clr during WRITE lets the strobe finish but discards the increment.
      if (clr) begin
        count_q    <= '0;
        mem_addr_q <= BASE_ADDR;
      end else if (state_q == S_WRITE) begin
        count_q    <= count_q + ONE;
        mem_addr_q <= mem_addr_q + 32'd4;
      end
      if (clr)                         err_q <= 1'b0;
      else if (accept && !enc_legal)   err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// Randomized self-checking bench for instr_encoder_loader against a transaction-level model.
module tb_instr_encoder_loader;
  localparam int          AW   = 2;
  localparam int          CAP  = 1 << AW;
  localparam logic [31:0] BASE = 32'h0000_0100;

  logic       clk;
  logic       reset;
  logic       clr;
  logic [1:0] dbg_state;

  instr_encoder_loader_if #(.ADDR_W(AW)) bus ();

  instr_encoder_loader #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  int          m_count  = 0;
  logic        m_err    = 1'b0;
  logic        m_full   = 1'b0;
  logic [31:0] obs_wdata;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_word(input int cls, input logic [31:0] rd,
      input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] f3,
      input logic f7b5, input logic [31:0] imm);
    logic [31:0] w;
    w = 32'h0;
    case (cls)
      0: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
      1: w = (((imm >> 5) & 32'h7f) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
             | ((imm & 32'h1f) << 7) | 32'h23;
      2: w = (f7b5 ? 32'h4000_0000 : 32'h0) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
             | (rd << 7) | 32'h33;
      3: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (rs2 << 20)
             | (rs1 << 15) | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 32'h1) << 7)
             | 32'h63;
      4: w = ((imm & 32'hfff) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
      5: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
             | (((imm >> 11) & 32'h1) << 20) | (imm & 32'h000f_f000) | (rd << 7) | 32'h6f;
      default: w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic ref_legal(input int cls, input logic [31:0] imm);
    int si;
    si = int'(imm);
    if (cls > 5) return 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    if ((cls == 0 || cls == 1 || cls == 4) && (si < -2048 || si > 2047)) return 1'b0;
    if (cls == 3 && (si < -4096 || si > 4094 || (si % 2) != 0)) return 1'b0;
    if (cls == 5 && (si < -1048576 || si > 1048574 || (si % 2) != 0)) return 1'b0;
`else
    if (si == 0 && si != 0) return 1'b0;
`endif
    return 1'b1;
  endfunction

  // ---------------- driver tasks (entered just after a falling edge) ----------------
  task automatic set_inputs(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5, input logic [31:0] imm);
    bus.in_class    = cls;
    bus.in_rd       = rd;
    bus.in_rs1      = rs1;
    bus.in_rs2      = rs2;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7b5;
    bus.in_imm      = imm;
  endtask

  task automatic drive_desc(input logic [2:0] cls, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic f7b5, input logic [31:0] imm);
    logic        legal;
    logic [31:0] w;
    legal = ref_legal(int'(cls), imm);
    w     = ref_word(int'(cls), 32'(rd), 32'(rs1), 32'(rs2), 32'(f3), f7b5, imm);
    check_eq("ready_pre", 32'(bus.in_ready), m_full ? 32'd0 : 32'd1);
    set_inputs(cls, rd, rs1, rs2, f3, f7b5, imm);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (m_full) begin
      bus.in_valid = 1'b0;
      check_eq("full_we", 32'(bus.mem_we), 32'd0);
      check_eq("full_cnt", 32'(bus.count), 32'(m_count));
      check_eq("full_flag", 32'(bus.full), 32'd1);
    end else if (legal) begin
      exp_q.push_back(w);
      check_eq("wr_we", 32'(bus.mem_we), 32'd1);
      check_eq("wr_ready", 32'(bus.in_ready), 32'd0);
      check_eq("wr_addr", bus.mem_addr, BASE + 32'(4 * m_count));
      check_eq("wr_data", bus.mem_wdata, exp_q.pop_front());
      check_eq("wr_cnt", 32'(bus.count), 32'(m_count));
      obs_wdata = bus.mem_wdata;
      // Hold valid with a different legal descriptor; it must not be taken.
      set_inputs(3'($urandom_range(0, 5)), 5'($urandom), 5'($urandom), 5'($urandom),
                 3'($urandom), 1'($urandom), 32'($urandom_range(0, 100)));
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      m_count++;
      m_full = (m_count == CAP);
      check_eq("post_we", 32'(bus.mem_we), 32'd0);
      check_eq("post_cnt", 32'(bus.count), 32'(m_count));
      check_eq("post_full", 32'(bus.full), 32'(m_full));
      check_eq("post_err", 32'(bus.err), 32'(m_err));
    end else begin
      bus.in_valid = 1'b0;
      m_err = 1'b1;
      check_eq("rej_we", 32'(bus.mem_we), 32'd0);
      check_eq("rej_err", 32'(bus.err), 32'd1);
      check_eq("rej_cnt", 32'(bus.count), 32'(m_count));
      check_eq("rej_ready", 32'(bus.in_ready), 32'd1);
    end
  endtask

  task automatic do_clr(input bit with_valid);
    clr = 1'b1;
    if (with_valid) begin
      set_inputs(3'd0, 5'd1, 5'd2, 5'd3, 3'd0, 1'b0, 32'd4);
      bus.in_valid = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    bus.in_valid = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    m_full  = 1'b0;
    check_eq("clr_cnt", 32'(bus.count), 32'd0);
    check_eq("clr_err", 32'(bus.err), 32'd0);
    check_eq("clr_full", 32'(bus.full), 32'd0);
    check_eq("clr_ready", 32'(bus.in_ready), 32'd1);
    check_eq("clr_addr", bus.mem_addr, BASE);
    check_eq("clr_we", 32'(bus.mem_we), 32'd0);
  endtask

  task automatic clr_in_write();
    set_inputs(3'd4, 5'd7, 5'd8, 5'd0, 3'd6, 1'b0, 32'd33);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("cw_we", 32'(bus.mem_we), 32'd1);
    check_eq("cw_data", bus.mem_wdata, ref_word(4, 32'd7, 32'd8, 32'd0, 32'd6, 1'b0, 32'd33));
    clr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    m_full  = 1'b0;
    check_eq("cw_cnt", 32'(bus.count), 32'd0);
    check_eq("cw_we_off", 32'(bus.mem_we), 32'd0);
    check_eq("cw_addr", bus.mem_addr, BASE);
  endtask

  task automatic rand_desc();
    logic [2:0]  cls;
    logic [31:0] imm;
    int          sel;
    cls = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    sel = $urandom_range(0, 3);
    case (sel)
      0:       imm = $urandom;
      1:       imm = 32'($urandom_range(0, 4095)) - 32'd2048;
      2:       imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      default: imm = 32'($urandom_range(0, 2097151)) - 32'd1048576;
    endcase
    drive_desc(cls, 5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), 1'($urandom), imm);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    clr   = 1'b0;
    bus.in_valid = 1'b0;
    set_inputs(3'd0, 5'd0, 5'd0, 5'd0, 3'd0, 1'b0, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(bus.in_ready), 32'd1);
    check_eq("rst_we", 32'(bus.mem_we), 32'd0);
    check_eq("rst_addr", bus.mem_addr, BASE);
    check_eq("rst_data", bus.mem_wdata, 32'd0);
    check_eq("rst_cnt", 32'(bus.count), 32'd0);
    check_eq("rst_full", 32'(bus.full), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    drive_desc(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8);
    check_eq("tp_lw", obs_wdata, 32'h0081_2283);
    drive_desc(3'd1, 5'd0, 5'd2, 5'd6, 3'd0, 1'b0, 32'd12);
    check_eq("tp_sw", obs_wdata, 32'h0061_2623);
    drive_desc(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0);
    check_eq("tp_add", obs_wdata, 32'h0020_81B3);
    drive_desc(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0);
    check_eq("tp_sub", obs_wdata, 32'h4020_81B3);
    check_eq("tp_full", 32'(bus.full), 32'd1);
    check_eq("tp_full_rdy", 32'(bus.in_ready), 32'd0);
    drive_desc(3'd0, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd4);
    do_clr(1'b0);

    drive_desc(3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFF_FFFC);
    check_eq("tp_beq", obs_wdata, 32'hFE20_8EE3);
    drive_desc(3'd5, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd8);
    check_eq("tp_jal", obs_wdata, 32'h0080_00EF);
    drive_desc(3'd7, 5'd1, 5'd1, 5'd1, 3'd0, 1'b0, 32'd0);
    check_eq("tp_ill_err", 32'(bus.err), 32'd1);
    do_clr(1'b0);
    drive_desc(3'd0, 5'd5, 5'd0, 5'd0, 3'd0, 1'b0, 32'd4096);
`ifdef ENC_RANGE_CHECK_EN
    check_eq("tp_rng_err", 32'(bus.err), 32'd1);
`else
    check_eq("tp_trunc", obs_wdata, 32'h0000_2283);
`endif
    do_clr(1'b1);
    clr_in_write();

    for (int i = 0; i < 200; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0) do_clr(1'($urandom));
      else if (r == 1 && !m_full) clr_in_write();
      else rand_desc();
    end

    // Reset in the middle of a write cycle.
    if (m_full) do_clr(1'b0);
    set_inputs(3'd0, 5'd9, 5'd3, 5'd0, 3'd0, 1'b0, 32'd16);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check_eq("ar_we_pre", 32'(bus.mem_we), 32'd1);
    #2 reset = 1'b1;
    #1;
    check_eq("ar_we", 32'(bus.mem_we), 32'd0);
    check_eq("ar_addr", bus.mem_addr, BASE);
    check_eq("ar_data", bus.mem_wdata, 32'd0);
    check_eq("ar_cnt", 32'(bus.count), 32'd0);
    check_eq("ar_ready", 32'(bus.in_ready), 32'd1);
    check_eq("ar_err", 32'(bus.err), 32'd0);
    check_eq("ar_full", 32'(bus.full), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    m_count = 0;
    m_err   = 1'b0;
    m_full  = 1'b0;
    @(negedge clk);
    drive_desc(3'd4, 5'd2, 5'd4, 5'd0, 3'd7, 1'b0, 32'hFFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
